// File: rtl/counter_pkg.sv
// Shared types and constants for the free-running counter and its sequence checker.
package counter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam int   DEF_WIDTH = 3;

endpackage

// File: rtl/count_step.sv
// Combinational +/-1 modulo 2^WIDTH step; shared by the counter and the checker's predictor.
module count_step
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  output logic [WIDTH-1:0] next_value
);

  assign next_value = (dir == DIR_UP) ? value + WIDTH'(1) : value - WIDTH'(1);

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side sequence checker: locks after LOCK_N in-order samples, then flags every break.
// Optional sticky error flag enabled by COUNTER_SEQ_CHECKER_STICKY_EN.
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_N    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 dir,
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
  input  logic                 clr_sticky,
  output logic                 err_sticky,
`endif
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int RUN_W = $clog2(LOCK_N + 1);

  state_t               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [WIDTH-1:0]     step_val;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 match;

  count_step #(.WIDTH(WIDTH)) u_step (
    .value      (in_count),
    .dir        (dir),
    .next_value (step_val)
  );

  assign match = (in_count == exp_q);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (in_valid) begin
      // Every valid sample re-seeds the prediction, so a break resyncs immediately.
      exp_d = step_val;
      case (state_q)
        UNLOCKED: begin
          run_d   = RUN_W'(1);
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            run_d = run_q + RUN_W'(1);
            if (int'(run_q) + 1 == LOCK_N) state_d = LOCKED;
          end else begin
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (!match) begin
            err_d   = 1'b1;
            run_d   = RUN_W'(1);
            state_d = ACQUIRE;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
        default: begin
          run_d   = '0;
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= UNLOCKED;
      run_q     <= '0;
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (clr_sticky) err_sticky_d = 1'b0;
    if (err_d)      err_sticky_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) err_sticky_q <= 1'b0;
    else       err_sticky_q <= err_sticky_d;
  end

  assign err_sticky = err_sticky_q;
`endif

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_cnt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker; a second instance with a 2-bit error counter covers saturation.
// Sticky-flag checks are active when COUNTER_SEQ_CHECKER_STICKY_EN is defined.
module tb_counter_seq_checker;

  logic       CLK;
  logic       RESET;
  logic       in_valid;
  logic [2:0] in_count;
  logic       dir;
  logic       locked, err;
  logic [7:0] err_count;
  logic [2:0] expected;
  logic       s_locked, s_err;
  logic [1:0] s_err_count;
  logic [2:0] s_expected;
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
  logic       clr_sticky;
  logic       err_sticky, s_err_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  counter_seq_checker dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .dir       (dir),
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    .clr_sticky(clr_sticky),
    .err_sticky(err_sticky),
`endif
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .expected  (expected)
  );

  counter_seq_checker #(.ERR_CNT_W(2)) dut_sat (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .dir       (dir),
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    .clr_sticky(clr_sticky),
    .err_sticky(s_err_sticky),
`endif
    .locked    (s_locked),
    .err       (s_err),
    .err_count (s_err_count),
    .expected  (s_expected)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive on the falling edge, then look at outputs 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [2:0] c, input logic d);
    @(negedge CLK);
    in_valid = v;
    in_count = c;
    dir      = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET    = 1'b0;
    in_valid = 1'b0;
    in_count = 3'd0;
    dir      = 1'b0;
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    clr_sticky = 1'b0;
`endif
    #1 RESET = 1'b1;
    #1;
    check("rst_locked",   32'(locked),    32'd0);
    check("rst_err",      32'(err),       32'd0);
    check("rst_err_cnt",  32'(err_count), 32'd0);
    check("rst_expected", 32'(expected),  32'd0);
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    check("rst_sticky",   32'(err_sticky), 32'd0);
`endif
    @(negedge CLK) RESET = 1'b0;

    // Up-count stream 0..7,0,1: lock after sample 3, hold through the wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i % 8), 1'b0);
      check("up_expected", 32'(expected), 32'((i + 1) % 8));
      check("up_locked",   32'(locked),   (i >= 3) ? 32'd1 : 32'd0);
      check("up_err",      32'(err),      32'd0);
    end
    check("up_err_cnt", 32'(err_count), 32'd0);

    // Break: 2,3 in order, then 5 instead of 4, then 6,7,0 re-lock.
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    check("brk_pre_locked", 32'(locked), 32'd1);
    step(1'b1, 3'd5, 1'b0);
    check("brk_err",      32'(err),       32'd1);
    check("brk_locked",   32'(locked),    32'd0);
    check("brk_err_cnt",  32'(err_count), 32'd1);
    check("brk_expected", 32'(expected),  32'd6);
    step(1'b1, 3'd6, 1'b0);
    check("brk_err_drop", 32'(err),    32'd0);
    check("brk_locked6",  32'(locked), 32'd0);
    step(1'b1, 3'd7, 1'b0);
    check("brk_locked7",  32'(locked), 32'd0);
    step(1'b1, 3'd0, 1'b0);
    check("brk_relock",   32'(locked),   32'd1);
    check("brk_exp1",     32'(expected), 32'd1);

    // Gap of 5 invalid cycles with garbage on in_count.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'(3 * i + 5), 1'(i));
      check("gap_expected", 32'(expected), 32'd1);
      check("gap_locked",   32'(locked),   32'd1);
      check("gap_err",      32'(err),      32'd0);
    end
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    check("gap_resume_err",    32'(err),      32'd0);
    check("gap_resume_locked", 32'(locked),   32'd1);
    check("gap_resume_exp",    32'(expected), 32'd3);

    // dir flip while locked: exactly one mismatch, then re-lock on the down stream.
    step(1'b1, 3'd1, 1'b1);
    check("flip_err",      32'(err),       32'd1);
    check("flip_err_cnt",  32'(err_count), 32'd2);
    check("flip_expected", 32'(expected),  32'd0);
    step(1'b1, 3'd0, 1'b1);
    check("flip_err_drop", 32'(err), 32'd0);
    step(1'b1, 3'd7, 1'b1);
    check("flip_unlocked", 32'(locked), 32'd0);
    step(1'b1, 3'd6, 1'b1);
    check("flip_relock",   32'(locked),   32'd1);
    check("flip_exp5",     32'(expected), 32'd5);
    check("flip_no_err",   32'(err),      32'd0);

    // Asynchronous reset mid-LOCKED, between edges.
    in_valid = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("arst_locked",   32'(locked),    32'd0);
    check("arst_err",      32'(err),       32'd0);
    check("arst_err_cnt",  32'(err_count), 32'd0);
    check("arst_expected", 32'(expected),  32'd0);
    @(negedge CLK) RESET = 1'b0;

    // Down-count from reset: 2,1,0,7,6 locks after sample 7.
    step(1'b1, 3'd2, 1'b1);
    check("dn_exp1", 32'(expected), 32'd1);
    step(1'b1, 3'd1, 1'b1);
    step(1'b1, 3'd0, 1'b1);
    check("dn_not_locked", 32'(locked), 32'd0);
    step(1'b1, 3'd7, 1'b1);
    check("dn_locked",  32'(locked),   32'd1);
    check("dn_exp6",    32'(expected), 32'd6);
    step(1'b1, 3'd6, 1'b1);
    check("dn_locked6", 32'(locked),    32'd1);
    check("dn_err",     32'(err),       32'd0);
    check("dn_err_cnt", 32'(err_count), 32'd0);

    // Saturation: four lock/break rounds, 2-bit counter stops at 3.
    in_valid = 1'b0;
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int s = 0; s < 4; s++) step(1'b1, 3'(s), 1'b0);
      check("sat_locked", 32'(s_locked), 32'd1);
      step(1'b1, 3'd5, 1'b0);
      check("sat_err",       32'(s_err),       32'd1);
      check("sat_cnt_small", 32'(s_err_count), (k < 3) ? 32'(k) : 32'd3);
      check("sat_cnt_wide",  32'(err_count),   32'(k));
    end
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    check("sticky_set", 32'(s_err_sticky), 32'd1);
    step(1'b0, 3'd0, 1'b0);
    check("sticky_hold", 32'(s_err_sticky), 32'd1);
    clr_sticky = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    clr_sticky = 1'b0;
    check("sticky_clr", 32'(s_err_sticky), 32'd0);
`else
    step(1'b0, 3'd0, 1'b0);
`endif
    check("sat_err_drop", 32'(s_err),       32'd0);
    check("sat_cnt_hold", 32'(s_err_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq_checker.md
# counter_seq_checker

Receive-side checker for the free-running case-style counter's `out` bus. It samples a WIDTH-bit count stream, acquires lock after LOCK_N consecutive correctly-sequenced samples, then flags every sequence break. Each error pulses one cycle and increments a saturating error counter. It sits downstream of the counter in lab bring-up designs and gives a self-checking pass/fail indication without a waveform viewer.

## Interface
- WIDTH, 3, bits of the observed count; the sequence wraps modulo 2^WIDTH.
- LOCK_N, 4, consecutive in-sequence samples needed to lock; legal range 2..15.
- ERR_CNT_W, 8, width of the saturating error counter.

- CLK  in  1  single clock; all sampling on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_count this cycle.
- in_count  in  WIDTH  observed counter value.
- dir  in  1  0 = up-count expected, 1 = down-count expected; sampled with each valid sample.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a sequence break while LOCKED.
- err_count  out  ERR_CNT_W  number of errors, saturating at all-ones.
- expected  out  WIDTH  next value the checker expects.

## Operation
- Step function: next(v) = v+1 mod 2^WIDTH if dir=0, v-1 mod 2^WIDTH if dir=1. 7→0 (up) and 0→7 (down) are legal wraps.
- States: UNLOCKED, ACQUIRE, LOCKED. run is an internal match counter, wide enough for LOCK_N.
- UNLOCKED, valid sample: expected←next(in_count), run←1, go to ACQUIRE.
- ACQUIRE, valid sample with in_count==expected: expected←next(in_count), run←run+1. Go to LOCKED when run+1==LOCK_N.
- ACQUIRE, valid mismatch: resync with expected←next(in_count), run←1. Stay in ACQUIRE. No err.
- LOCKED, valid match: expected←next(in_count).
- LOCKED, valid mismatch: err←1 for one cycle, err_count saturating +1, expected←next(in_count), run←1, go to ACQUIRE.
- in_valid low: state, run, expected and err_count hold. err returns to 0.
- A dir change is only applied to the next prediction. A dir flip while LOCKED therefore produces exactly one mismatch.
- err_count never wraps.

## Timing
- All outputs are registered. An outcome is visible the cycle after the sampling edge (1-cycle latency).
- locked rises on the edge that takes the LOCK_N-th consecutive valid in-sequence sample. It falls on the edge that takes the mismatching sample, the same edge that raises err.
- err is high for exactly one cycle per mismatch, including back-to-back valid cycles.
- RESET asserted at any time, including mid-LOCKED, immediately forces: state UNLOCKED, run 0, locked 0, err 0, err_count 0, expected 0. No clock edge is needed.
- First valid edge after RESET deasserts is treated as an UNLOCKED sample.

## Configuration
- COUNTER_SEQ_CHECKER_STICKY_EN defined:
  - adds output err_sticky (1 bit) and input clr_sticky (1 bit);
  - err_sticky sets on any err and holds until clr_sticky is high at an edge or RESET;
  - if set and clear occur on the same edge, set wins;
  - reset value 0.
- COUNTER_SEQ_CHECKER_STICKY_EN undefined: neither port exists, and behaviour is otherwise identical.

## Structure
- Package counter_pkg holds:
  - state enum {UNLOCKED, ACQUIRE, LOCKED};
  - DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - default WIDTH constant, shared with the counter.
- One sub-module: count_step, a combinational WIDTH-bit next-value (±1 modulo) function. It is instantiated for the prediction and is reusable by the counter itself.
- FSM, run counter, error counter and optional sticky flag live in the top module.

## Test plan
- Reset, dir=0, valid every cycle with 0,1,2,…,7,0,1 → locked rises after the sample 3 edge, stays high through the 7→0 wrap, err never pulses, err_count=0.
- Locked on up-stream after 3, feed 5 instead of 4, then 6,7,0 → err pulses one cycle after 5, err_count=1, locked low, re-locks on the edge sampling 0.
- dir=1, feed 2,1,0,7,6 → locked after the sample 7 edge, no err.
- Locked, drop in_valid for 5 cycles with garbage on in_count, resume in sequence → no err, locked stays high, expected unchanged during the gap.
- Assert RESET asynchronously mid-LOCKED between edges → locked, err, err_count and expected read 0 before the next CLK edge.
- ERR_CNT_W=2, macro defined: force 4 lock/break cycles → err_count saturates at 3, err_sticky=1. Then clr_sticky for one edge → err_sticky=0, err_count still 3.
